// File: rtl/tick_sched_pkg.sv
// Shared constants and helpers for the tick event scheduler and its arbiter.
// Defaults describe a 4-channel, 8-bit-period, divide-by-4 instance.
package tick_sched_pkg;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_PERIOD_W    = 8;
    localparam int DEF_PRESCALE    = 4;
    localparam int DISABLED_PERIOD = 0;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
// No state here; the caller owns the pointer and the output register.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] last_grant,
    input  logic          en,
    output logic          grant_valid,
    output logic [CW-1:0] grant_idx
);

    int c;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        c           = 0;
        for (int off = 1; off <= N; off++) begin
            c = (int'(last_grant) + off) % N;
            if (en && !grant_valid && req[c]) begin
                grant_valid = 1'b1;
                grant_idx   = CW'(c);
            end
        end
    end

endmodule

// File: rtl/tick_event_scheduler.sv
// Multi-channel periodic timer: shared prescaler, per-channel countdowns, round-robin
// event port (2 cycles expiry->evt_valid, holds under backpressure). ONESHOT_EN adds cfg_oneshot.
module tick_event_scheduler
    import tick_sched_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int PERIOD_W = DEF_PERIOD_W,
    parameter int PRESCALE = DEF_PRESCALE,
    localparam int CW      = idx_w(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cfg_we,
`ifdef ONESHOT_EN
    input  logic                cfg_oneshot,
`endif
    input  logic [CW-1:0]       cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CW-1:0]       evt_ch,
    output logic [N_CH-1:0]     toggle_out,
    output logic [N_CH-1:0]     overrun
);

    localparam int PW = idx_w(PRESCALE);

    logic [PW-1:0]       pre;
    logic [PERIOD_W-1:0] period [N_CH];
    logic [PERIOD_W-1:0] cnt    [N_CH];
    logic [N_CH-1:0]     pending;
    logic [CW-1:0]       last_grant;
`ifdef ONESHOT_EN
    logic [N_CH-1:0]     oneshot;
`endif

    logic                tick;
    logic                free;
    logic                grant_valid;
    logic [CW-1:0]       grant_idx;
    logic [N_CH-1:0]     granted;
    logic [N_CH-1:0]     cfg_sel;

    assign tick = enable && (pre == PW'(PRESCALE - 1));
    assign free = !evt_valid || evt_ready;

    rr_arbiter #(.N(N_CH), .CW(CW)) u_arb (
        .req         (pending),
        .last_grant  (last_grant),
        .en          (free),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        granted = '0;
        cfg_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            granted[i] = grant_valid && (grant_idx == CW'(i));
            cfg_sel[i] = cfg_we && (cfg_ch == CW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre        <= '0;
            pending    <= '0;
            toggle_out <= '0;
            overrun    <= '0;
            evt_valid  <= 1'b0;
            evt_ch     <= '0;
            last_grant <= CW'(N_CH - 1);
`ifdef ONESHOT_EN
            oneshot    <= '0;
`endif
            for (int i = 0; i < N_CH; i++) begin
                period[i] <= PERIOD_W'(DISABLED_PERIOD);
                cnt[i]    <= '0;
            end
        end else begin
            if (enable) begin
                pre <= tick ? '0 : pre + 1'b1;
            end

            if (grant_valid) begin
                evt_valid  <= 1'b1;
                evt_ch     <= grant_idx;
                last_grant <= grant_idx;
            end else if (free) begin
                evt_valid <= 1'b0;
            end

            for (int i = 0; i < N_CH; i++) begin
                if (cfg_sel[i]) begin
                    // A config write swallows any same-cycle expiry on this channel.
                    period[i]  <= cfg_period;
                    cnt[i]     <= (cfg_period == '0) ? '0 : cfg_period - 1'b1;
                    pending[i] <= 1'b0;
                    overrun[i] <= 1'b0;
`ifdef ONESHOT_EN
                    oneshot[i] <= cfg_oneshot;
`endif
                end else begin
                    if (granted[i]) begin
                        pending[i] <= 1'b0;
                    end
                    if (tick && period[i] != PERIOD_W'(DISABLED_PERIOD)) begin
                        if (cnt[i] == '0) begin
                            cnt[i]        <= period[i] - 1'b1;
                            toggle_out[i] <= ~toggle_out[i];
                            // A pending event being granted right now is not lost.
                            if (pending[i] && !granted[i]) begin
                                overrun[i] <= 1'b1;
                            end else begin
                                pending[i] <= 1'b1;
                            end
`ifdef ONESHOT_EN
                            if (oneshot[i]) begin
                                period[i] <= PERIOD_W'(DISABLED_PERIOD);
                            end
`endif
                        end else begin
                            cnt[i] <= cnt[i] - 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_event_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle
// against a tick-counting reference model of the scheduler.
module tb_tick_event_scheduler;

    localparam int N  = 4;
    localparam int PS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_period;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic [3:0] toggle_out;
    logic [3:0] overrun;
`ifdef ONESHOT_EN
    logic       cfg_oneshot;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: rem_m counts ticks remaining until the next expiry.
    int pre_m;
    int per_m  [N];
    int rem_m  [N];
    bit pend_m [N];
    bit ovr_m  [N];
    bit tog_m  [N];
    bit os_m   [N];
    bit vld_m;
    int ech_m;
    int last_m;

    always #5 clk = ~clk;

    tick_event_scheduler #(.N_CH(N), .PERIOD_W(8), .PRESCALE(PS)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cfg_we      (cfg_we),
`ifdef ONESHOT_EN
        .cfg_oneshot (cfg_oneshot),
`endif
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .toggle_out  (toggle_out),
        .overrun     (overrun)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tick;
        bit free;
        bit np;
        int gnt;
        int c;
        if (rst) begin
            pre_m = 0;
            for (int i = 0; i < N; i++) begin
                per_m[i] = 0; rem_m[i] = 0; pend_m[i] = 0;
                ovr_m[i] = 0; tog_m[i] = 0; os_m[i] = 0;
            end
            vld_m  = 0;
            ech_m  = 0;
            last_m = N - 1;
            return;
        end
        tick = enable && (pre_m == PS - 1);
        if (enable) pre_m = tick ? 0 : pre_m + 1;
        free = !vld_m || evt_ready;
        gnt  = -1;
        if (free) begin
            for (int k = 1; k <= N; k++) begin
                c = (last_m + k) % N;
                if (gnt < 0 && pend_m[c]) gnt = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (cfg_we && int'(cfg_ch) == i) begin
                per_m[i]  = int'(cfg_period);
                rem_m[i]  = int'(cfg_period);
                pend_m[i] = 0;
                ovr_m[i]  = 0;
`ifdef ONESHOT_EN
                os_m[i]   = cfg_oneshot;
`endif
            end else begin
                np = pend_m[i] && (gnt != i);
                if (tick && per_m[i] != 0) begin
                    rem_m[i]--;
                    if (rem_m[i] == 0) begin
                        tog_m[i] = !tog_m[i];
                        if (np) ovr_m[i] = 1;
                        else    np = 1;
                        rem_m[i] = per_m[i];
                        if (os_m[i]) per_m[i] = 0;
                    end
                end
                pend_m[i] = np;
            end
        end
        if (gnt >= 0) begin
            vld_m  = 1;
            ech_m  = gnt;
            last_m = gnt;
        end else if (free) begin
            vld_m = 0;
        end
    endtask

    task automatic compare_all();
        chk_eq("evt_valid", evt_valid, vld_m);
        chk_eq("evt_ch", evt_ch, ech_m);
        for (int i = 0; i < N; i++) begin
            chk_eq("toggle_out", toggle_out[i], tog_m[i]);
            chk_eq("overrun", overrun[i], ovr_m[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1; enable = 0; cfg_we = 0; evt_ready = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic cfg_write(input int ch, input int p);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_period = 8'(p);
`ifdef ONESHOT_EN
        cfg_oneshot = 0;
`endif
        step();
        cfg_we = 0;
    endtask

    initial begin
        int n;
        int prev;
        bit found;

        rst = 1; enable = 0; cfg_we = 0; cfg_ch = 0; cfg_period = 0; evt_ready = 0;
`ifdef ONESHOT_EN
        cfg_oneshot = 0;
`endif
        do_reset();
        chk_eq("rst_evt_valid", evt_valid, 0);
        chk_eq("rst_evt_ch", evt_ch, 0);
        chk_eq("rst_toggle", toggle_out, 0);
        chk_eq("rst_overrun", overrun, 0);

        // ch0 period 3: one event every 12 clocks.
        cfg_write(0, 3);
        enable = 1; evt_ready = 1;
        n = 0; prev = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            step();
            if (evt_valid && evt_ch == 0) begin
                if (prev >= 0) chk_eq("p1_interval", cyc - prev, 12);
                prev = cyc;
                n++;
            end
        end
        chk_eq("p1_count_ge4", n >= 4, 1);

        // All channels period 1: grants rotate 0,1,2,3 with no overrun.
        do_reset();
        for (int i = 0; i < N; i++) cfg_write(i, 1);
        enable = 1; evt_ready = 1;
        prev = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (evt_valid) begin
                if (prev >= 0) chk_eq("p3_order", evt_ch, (prev + 1) % N);
                prev = int'(evt_ch);
            end
        end
        chk_eq("p3_overrun", overrun, 0);

        // ch1 period 1 under backpressure: overrun, then drain exactly two events.
        do_reset();
        cfg_write(1, 1);
        enable = 1; evt_ready = 0;
        for (int cyc = 0; cyc < 20; cyc++) step();
        chk_eq("p4_overrun", overrun[1], 1);
        chk_eq("p4_hold_ch", evt_ch, 1);
        enable = 0; evt_ready = 1;
        n = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (evt_valid && evt_ready) n++;
            step();
        end
        chk_eq("p4_drain", n, 2);

        // Rewrite ch2 in the very cycle it would expire.
        do_reset();
        cfg_write(2, 2);
        enable = 1; evt_ready = 1;
        found = 0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            if (pre_m == PS - 1 && rem_m[2] == 1) found = 1;
            else step();
        end
        chk_eq("p5_sync", found, 1);
        cfg_write(2, 5);
        n = 0;
        found = 0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            step();
            n++;
            if (evt_valid && evt_ch == 2) found = 1;
        end
        chk_eq("p5_latency", n, 21);

        // Reset in the middle of a stalled handshake.
        do_reset();
        cfg_write(1, 1);
        enable = 1; evt_ready = 0;
        for (int cyc = 0; cyc < 20; cyc++) step();
        rst = 1;
        step();
        rst = 0;
        chk_eq("p6_valid", evt_valid, 0);
        chk_eq("p6_overrun", overrun, 0);
        chk_eq("p6_toggle", toggle_out, 0);
        evt_ready = 1;
        n = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            if (evt_valid) n++;
        end
        chk_eq("p6_no_events", n, 0);

`ifdef ONESHOT_EN
        do_reset();
        cfg_we = 1; cfg_ch = 3; cfg_period = 2; cfg_oneshot = 1;
        step();
        cfg_we = 0; cfg_oneshot = 0;
        enable = 1; evt_ready = 1;
        n = 0;
        for (int cyc = 0; cyc < 110; cyc++) begin
            step();
            if (evt_valid && evt_ch == 3) n++;
        end
        chk_eq("os_count", n, 1);
`endif

        // Random traffic against the model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst        = ($urandom_range(0, 499) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            evt_ready  = ($urandom_range(0, 3) != 0);
            cfg_we     = ($urandom_range(0, 11) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'($urandom_range(0, 5));
`ifdef ONESHOT_EN
            cfg_oneshot = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_event_scheduler.md
Name: tick_event_scheduler

Overview:
- Programmable multi-channel periodic timer scheduler.
- One shared prescaler produces a base tick. Each channel counts base ticks down and raises an event on expiry.
- A round-robin arbiter serialises pending events onto one valid/ready event port.
- Sequences and shares the counter/toggle/timer primitives used across the behavioural testbench infrastructure: one controller replaces ad-hoc parallel timers.

Parameters:
- N_CH, 4, number of timer channels (2..16).
- PERIOD_W, 8, width of each channel period/countdown.
- PRESCALE, 4, clock cycles per base tick (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  advances the prescaler and channel counters when 1.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  $clog2(N_CH)  channel being written.
- cfg_period  in  PERIOD_W  new period in base ticks; 0 disables the channel.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_ch  out  $clog2(N_CH)  channel that produced the event.
- toggle_out  out  N_CH  per-channel square wave; inverts on every expiry.
- overrun  out  N_CH  sticky: an expiry was lost because that channel's event was still pending.

Behaviour:
- Reset (clk edge with rst=1): prescaler=0, all periods=0, countdowns=0, pending=0, toggle_out=0, overrun=0, evt_valid=0, evt_ch=0, RR pointer set so channel 0 has first priority. rst overrides all other inputs, including mid-handshake.
- Prescaler: counts 0..PRESCALE-1 while enable=1, then wraps. tick=1 in the cycle the count equals PRESCALE-1 and enable=1. With enable=0 the prescaler and countdowns hold.
- Channel on tick with period P≠0:
  - cnt==0: expire, cnt←P-1.
  - otherwise: cnt←cnt-1.
  - Result: one expiry every P ticks, i.e. every P·PRESCALE clocks.
- Channel with P=0: never expires; cnt holds.
- Expiry: toggle_out[ch] inverts. If pending[ch]=0, set pending[ch]; else set overrun[ch] and leave pending[ch] at 1 (events coalesce).
- Config write (cfg_we=1): period[cfg_ch]←cfg_period, cnt←cfg_period-1 (0 if cfg_period=0), pending[cfg_ch]←0, overrun[cfg_ch]←0. A write wins over a same-cycle expiry on that channel: no event, no toggle. An out-of-range cfg_ch is ignored.
- Arbiter:
  - Output register is free when evt_valid=0 or (evt_valid & evt_ready).
  - When free and any pending bit is set, select the first set bit starting at last_grant+1 (mod N_CH). Load evt_ch, set evt_valid, clear that pending bit, last_grant←winner.
  - A channel's pending bit that is set in the same cycle its grant is loaded is kept, not lost.
  - When free and nothing is pending, evt_valid←0.
  - At most one grant per cycle.
- Handshake: while evt_valid=1 and evt_ready=0, evt_ch holds stable. evt_valid never drops without acceptance, except on rst.
- Latency: expiry in tick cycle t → pending at t+1 → evt_valid visible at t+2 when the output register is free. Back-to-back acceptance sustains 1 event/cycle.
- Widths: countdown arithmetic is unsigned PERIOD_W, with no wrap below 0 because 0 triggers a reload.

Optional Feature:
- ONESHOT_EN defined:
  - Adds input cfg_oneshot (1 bit), captured per channel on cfg_we.
  - A one-shot channel expires once, then its period is cleared to 0.
  - Its event and toggle still occur.
- ONESHOT_EN undefined:
  - Port absent; all channels periodic.
  - Logic otherwise identical.

Decomposition:
- Package tick_sched_pkg holds:
  - channel-index width function (clog2 helper)
  - default N_CH/PERIOD_W/PRESCALE constants
  - the DISABLED_PERIOD=0 constant
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N], last_grant, en.
  - Combinational outputs: grant_valid and grant_idx.
  - The scheduler owns the registered output and pointer.

Test Plan (N_CH=4, PERIOD_W=8, PRESCALE=4):
- Reset; write ch0 period 3; enable=1, evt_ready=1 → evt_valid pulses with evt_ch=0 every 12 clocks; toggle_out[0] inverts each event; overrun stays 0.
- All four channels period 1, evt_ready=1 → per tick, grants on consecutive cycles in order 0,1,2,3; order repeats; no overrun.
- Only ch1 period 1, evt_ready=0 → evt_valid=1 with evt_ch=1 holds; next expiry sets pending; the expiry after that sets overrun[1]. Raising evt_ready delivers exactly one more ch1 event.
- cfg write ch2 period 5 in the same cycle ch2 would expire → no event, toggle_out[2] unchanged; next ch2 event arrives 5 ticks later.
- rst asserted while evt_valid=1, evt_ready=0 → next cycle evt_valid=0, overrun=0, toggle_out=0; no events until reprogrammed.
- ONESHOT_EN: ch3 period 2, cfg_oneshot=1 → exactly one ch3 event after 8 clocks, then none over 100 clocks.
